// File: rtl/fp_apu_dispatcher.sv
// FP op dispatcher: queues core FP ops, issues them to the FPU wrapper over req/gnt,
// and tags in-order results for writeback. Optional sticky flags: FP_DISPATCH_FFLAGS_EN.
//
// state | meaning
// IDLE  | nothing presented to the FPU
// REQ   | head entry presented; apu_req_o and payload held until apu_gnt_i
module fp_apu_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [95:0] in_operands_i,
    input  logic [5:0]  in_op_i,
    input  logic [2:0]  in_rnd_i,
    input  logic [4:0]  in_rd_i,
    input  logic        flush_i,
    output logic        apu_req_o,
    input  logic        apu_gnt_i,
    output logic [95:0] apu_operands_o,
    output logic [5:0]  apu_op_o,
    output logic [10:0] apu_flags_o,
    input  logic        apu_rvalid_i,
    input  logic [31:0] apu_rdata_i,
    input  logic [4:0]  apu_rflags_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_fflags_o,
    input  logic        fflags_clr_i,
    output logic [4:0]  fflags_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int TPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int TCW = $clog2(MAX_OUT) + 1;

    typedef struct packed {
        logic [95:0] operands;
        logic [5:0]  op;
        logic [2:0]  rnd;
        logic [4:0]  rd;
    } entry_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t          state_q, state_d;
    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      tag_q [MAX_OUT];
    logic [TPW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [TCW-1:0]  out_cnt_q, out_cnt_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [4:0]      wb_fflags_q, wb_fflags_d;

    entry_t in_entry, head;
    logic   full, push, issue;
    logic   tag_empty, rsp_tag_pop, rsp_bypass, rsp_accept, tag_push;
    logic   can_issue_next;

    function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
        return (p == TPW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_entry    = '{operands: in_operands_i, op: in_op_i, rnd: in_rnd_i, rd: in_rd_i};
    assign head        = fifo_q[rd_ptr_q];
    assign full        = (count_q == CW'(DEPTH));
    assign in_ready_o  = !full && !flush_i;
    assign push        = in_valid_i && in_ready_o;
    assign issue       = apu_req_o && apu_gnt_i;
    assign tag_empty   = (out_cnt_q == '0);
    assign rsp_tag_pop = apu_rvalid_i && !tag_empty;
    // a result arriving in the very cycle of its own grant has no queued tag yet
    assign rsp_bypass  = apu_rvalid_i && tag_empty && issue;
    assign rsp_accept  = rsp_tag_pop || rsp_bypass;
    assign tag_push    = issue && !rsp_bypass;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush_i) begin
            // an entry already presented to the FPU survives the flush
            if (apu_req_o && !issue) begin
                wr_ptr_d = rd_ptr_q + 1'b1;
                count_d  = CW'(1);
            end else begin
                wr_ptr_d = rd_ptr_d;
                count_d  = '0;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(issue);
        end
    end

    always_comb begin
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        if (tag_push) begin
            tag_wr_d = tag_inc(tag_wr_q);
        end
        if (rsp_tag_pop) begin
            tag_rd_d = tag_inc(tag_rd_q);
        end
        out_cnt_d = out_cnt_q + TCW'(tag_push) - TCW'(rsp_tag_pop);
    end

    always_comb begin
        wb_valid_d  = rsp_accept;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_fflags_d = wb_fflags_q;
        if (rsp_accept) begin
            wb_rd_d     = rsp_tag_pop ? tag_q[tag_rd_q] : head.rd;
            wb_data_d   = apu_rdata_i;
            wb_fflags_d = apu_rflags_i;
        end
    end

    assign can_issue_next = (count_d != '0) && (out_cnt_d < TCW'(MAX_OUT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (can_issue_next) state_d = S_REQ;
            S_REQ:   if (apu_gnt_i && !can_issue_next) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        apu_req_o = (state_q == S_REQ);
    end

    assign apu_operands_o = head.operands;
    assign apu_op_o       = head.op;
    assign apu_flags_o    = {2'b10, 6'b0, head.rnd};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            out_cnt_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_fflags_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            out_cnt_q   <= out_cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_fflags_q <= wb_fflags_d;
        end
    end

    // storage arrays carry no reset; occupancy is tracked by the counters above
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_entry;
        end
        if (tag_push) begin
            tag_q[tag_wr_q] <= head.rd;
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign wb_fflags_o = wb_fflags_q;

`ifdef FP_DISPATCH_FFLAGS_EN
    logic [4:0] fflags_q, fflags_d;

    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i) begin
            fflags_d = '0;
        end else if (wb_valid_q) begin
            fflags_d = fflags_q | wb_fflags_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_o = fflags_q;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr_i;
    assign fflags_o          = '0;
`endif

endmodule

// File: tb/tb_fp_apu_dispatcher.sv
// Bench for fp_apu_dispatcher: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fp_apu_dispatcher;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [95:0] in_operands_i = '0;
    logic [5:0]  in_op_i = '0;
    logic [2:0]  in_rnd_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        apu_req_o;
    logic        apu_gnt_i = 1'b0;
    logic [95:0] apu_operands_o;
    logic [5:0]  apu_op_o;
    logic [10:0] apu_flags_o;
    logic        apu_rvalid_i = 1'b0;
    logic [31:0] apu_rdata_i = '0;
    logic [4:0]  apu_rflags_i = '0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_fflags_o;
    logic        fflags_clr_i = 1'b0;
    logic [4:0]  fflags_o;

    fp_apu_dispatcher #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_operands_i(in_operands_i), .in_op_i(in_op_i), .in_rnd_i(in_rnd_i), .in_rd_i(in_rd_i),
        .flush_i(flush_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_fflags_o(wb_fflags_o),
        .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [95:0] opnd;
        logic [5:0]  op;
        logic [2:0]  rnd;
        logic [4:0]  rd;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  mtags[$];
    bit          model_on = 0;
    bit          m_req = 0;
    bit          m_wbv = 0;
    logic [4:0]  m_wbrd = '0;
    logic [31:0] m_wbdata = '0;
    logic [4:0]  m_wbff = '0;
    logic [4:0]  m_ff = '0;
    bit          g, p, acc, byp;
    logic [4:0]  tg;
    ent_t        ne;

    always @(negedge clk_i) begin
        if (model_on) begin
            chk("apu_req", apu_req_o, m_req);
            chk("in_ready", in_ready_o, (mq.size() < DEPTH) && !flush_i);
            if (m_req) begin
                chk("apu_operands", apu_operands_o, mq[0].opnd);
                chk("apu_op", apu_op_o, mq[0].op);
                chk("apu_flags", apu_flags_o, {2'b10, 6'b0, mq[0].rnd});
            end
            chk("wb_valid", wb_valid_o, m_wbv);
            if (m_wbv) begin
                chk("wb_rd", wb_rd_o, m_wbrd);
                chk("wb_data", wb_data_o, m_wbdata);
                chk("wb_fflags", wb_fflags_o, m_wbff);
            end
            chk("fflags", fflags_o, m_ff);
        end
        if (rst_i) begin
            mq.delete();
            mtags.delete();
            m_req = 0; m_wbv = 0; m_wbrd = '0; m_wbdata = '0; m_wbff = '0; m_ff = '0;
            model_on = 1;
        end else if (model_on) begin
            g   = m_req && apu_gnt_i;
            p   = in_valid_i && (mq.size() < DEPTH) && !flush_i;
            acc = 0; byp = 0; tg = '0;
            if (apu_rvalid_i) begin
                if (mtags.size() > 0) begin
                    acc = 1; tg = mtags.pop_front();
                end else if (g) begin
                    acc = 1; byp = 1; tg = mq[0].rd;
                end
            end
            if (g && !byp) mtags.push_back(mq[0].rd);
`ifdef FP_DISPATCH_FFLAGS_EN
            if (fflags_clr_i) m_ff = '0;
            else if (m_wbv) m_ff = m_ff | m_wbff;
`endif
            m_wbv = acc;
            if (acc) begin
                m_wbrd = tg; m_wbdata = apu_rdata_i; m_wbff = apu_rflags_i;
            end
            if (g) void'(mq.pop_front());
            if (flush_i) begin
                if (m_req && !g) begin
                    while (mq.size() > 1) void'(mq.pop_back());
                end else begin
                    mq.delete();
                end
            end else if (p) begin
                ne = '{opnd: in_operands_i, op: in_op_i, rnd: in_rnd_i, rd: in_rd_i};
                mq.push_back(ne);
            end
            m_req = (mq.size() > 0) && (mtags.size() < MAX_OUT);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        in_valid_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0; flush_i = 0; fflags_clr_i = 0;
        apu_rflags_i = '0;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [5:0] op, input logic [2:0] rnd);
        in_valid_i    = 1;
        in_rd_i       = rd;
        in_op_i       = op;
        in_rnd_i      = rnd;
        in_operands_i = {27'h0, rd, 26'h0, op, 29'h0, rnd};
    endtask

    logic [4:0] exp_ff;

    initial begin
        // reset
        tick(); tick();
        rst_i = 0;
        #1;
        chk("lit_rst_req", apu_req_o, 1'b0);
        chk("lit_rst_ready", in_ready_o, 1'b1);
        chk("lit_rst_wbv", wb_valid_o, 1'b0);
        chk("lit_rst_wbrd", wb_rd_o, 5'd0);
        chk("lit_rst_wbdata", wb_data_o, 32'd0);
        chk("lit_rst_wbff", wb_fflags_o, 5'd0);
        chk("lit_rst_fflags", fflags_o, 5'd0);
        tick();

        // single op
        offer(5'd3, 6'b001100, 3'b010);
        tick();
        in_valid_i = 0; apu_gnt_i = 1;
        #1;
        chk("lit_single_req", apu_req_o, 1'b1);
        chk("lit_single_op", apu_op_o, 6'b001100);
        chk("lit_single_flags", apu_flags_o, 11'b10_000000_010);
        tick();
        apu_gnt_i = 0; apu_rvalid_i = 1; apu_rdata_i = 32'h3F800000;
        #1;
        chk("lit_single_req_drop", apu_req_o, 1'b0);
        tick();
        apu_rvalid_i = 0;
        #1;
        chk("lit_single_wbv", wb_valid_o, 1'b1);
        chk("lit_single_wbrd", wb_rd_o, 5'd3);
        chk("lit_single_wbdata", wb_data_o, 32'h3F800000);
        tick();
        #1;
        chk("lit_single_wbv_pulse", wb_valid_o, 1'b0);
        tick();

        // full queue, then drain with zero-latency results
        for (int i = 0; i < 4; i++) begin
            offer(5'(10 + i), 6'(i + 1), 3'(i));
            tick();
        end
        offer(5'd31, 6'h3F, 3'd7);
        #1;
        chk("lit_full_ready", in_ready_o, 1'b0);
        chk("lit_full_req", apu_req_o, 1'b1);
        chk("lit_full_head", apu_operands_o, {27'h0, 5'd10, 26'h0, 6'd1, 29'h0, 3'd0});
        tick();
        tick();
        in_valid_i = 0;
        for (int k = 0; k < 6; k++) begin
            apu_gnt_i = 1; apu_rvalid_i = 1; apu_rdata_i = 32'(32'h100 + k);
            if (k == 1) begin
                #1;
                chk("lit_bypass_wbv", wb_valid_o, 1'b1);
                chk("lit_bypass_wbrd", wb_rd_o, 5'd10);
                chk("lit_bypass_wbdata", wb_data_o, 32'h100);
            end
            tick();
        end
        idle_in();
        #1;
        chk("lit_orphan_rvalid", wb_valid_o, 1'b0);
        tick();

        // outstanding limit
        offer(5'd20, 6'd5, 3'd1); apu_gnt_i = 1;
        tick();
        offer(5'd21, 6'd6, 3'd1);
        tick();
        offer(5'd22, 6'd7, 3'd1);
        tick();
        in_valid_i = 0;
        #1;
        chk("lit_maxout_req0", apu_req_o, 1'b0);
        tick();
        apu_gnt_i = 0;
        #1;
        chk("lit_maxout_req0_hold", apu_req_o, 1'b0);
        tick();
        apu_rvalid_i = 1; apu_rdata_i = 32'hAAAA0000;
        tick();
        apu_rvalid_i = 0; apu_gnt_i = 1;
        #1;
        chk("lit_maxout_rereq", apu_req_o, 1'b1);
        chk("lit_maxout_wbrd", wb_rd_o, 5'd20);
        tick();
        apu_gnt_i = 0; apu_rvalid_i = 1; apu_rdata_i = 32'hAAAA0001;
        tick();
        apu_rdata_i = 32'hAAAA0002;
        tick();
        idle_in();
        tick();

        // flush with head presented
        for (int i = 0; i < 3; i++) begin
            offer(5'(7 + i), 6'(20 + i), 3'd4);
            tick();
        end
        offer(5'd30, 6'd30, 3'd0); flush_i = 1;
        #1;
        chk("lit_flush_ready", in_ready_o, 1'b0);
        chk("lit_flush_req", apu_req_o, 1'b1);
        tick();
        idle_in();
        #1;
        chk("lit_flush_head_kept", apu_operands_o, {27'h0, 5'd7, 26'h0, 6'd20, 29'h0, 3'd4});
        tick();
        apu_gnt_i = 1;
        tick();
        #1;
        chk("lit_flush_rest_gone", apu_req_o, 1'b0);
        tick();
        apu_rvalid_i = 1; apu_rdata_i = 32'h0000_0777;
        #1;
        chk("lit_flush_rest_gone2", apu_req_o, 1'b0);
        tick();
        idle_in();
        #1;
        chk("lit_flush_wbrd", wb_rd_o, 5'd7);
        tick();

        // sticky flags
        offer(5'd1, 6'd2, 3'd0);
        tick();
        offer(5'd2, 6'd3, 3'd0); apu_gnt_i = 1;
        tick();
        in_valid_i = 0; apu_rvalid_i = 1; apu_rdata_i = 32'h11; apu_rflags_i = 5'b00001;
        tick();
        apu_gnt_i = 0; apu_rdata_i = 32'h22; apu_rflags_i = 5'b10000;
        tick();
        idle_in();
        tick();
`ifdef FP_DISPATCH_FFLAGS_EN
        exp_ff = 5'b10001;
`else
        exp_ff = 5'b00000;
`endif
        #1;
        chk("lit_fflags_or", fflags_o, exp_ff);
        fflags_clr_i = 1;
        tick();
        fflags_clr_i = 0;
        #1;
        chk("lit_fflags_clr", fflags_o, 5'd0);
        offer(5'd4, 6'd9, 3'd0);
        tick();
        in_valid_i = 0; apu_gnt_i = 1;
        tick();
        apu_gnt_i = 0; apu_rvalid_i = 1; apu_rflags_i = 5'b00100;
        tick();
        idle_in(); fflags_clr_i = 1;
        tick();
        fflags_clr_i = 0;
        #1;
        chk("lit_fflags_clr_wins", fflags_o, 5'd0);
        tick();

        // reset while requesting
        offer(5'd5, 6'd1, 3'd0);
        tick();
        in_valid_i = 0;
        #1;
        chk("lit_midrst_req", apu_req_o, 1'b1);
        rst_i = 1;
        tick();
        rst_i = 0;
        #1;
        chk("lit_midrst_req_drop", apu_req_o, 1'b0);
        chk("lit_midrst_ready", in_ready_o, 1'b1);
        tick();
        tick();

        // mixed traffic against the model
        for (int n = 0; n < 300; n++) begin
            in_valid_i    = 1'($urandom_range(0, 1));
            in_rd_i       = 5'($urandom_range(0, 31));
            in_op_i       = 6'($urandom_range(0, 63));
            in_rnd_i      = 3'($urandom_range(0, 7));
            in_operands_i = {$urandom, $urandom, $urandom};
            apu_gnt_i     = 1'($urandom_range(0, 1));
            apu_rvalid_i  = ($urandom_range(0, 2) == 0);
            apu_rdata_i   = $urandom;
            apu_rflags_i  = 5'($urandom_range(0, 31));
            flush_i       = ($urandom_range(0, 15) == 0);
            fflags_clr_i  = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle_in();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
